alu_seq_unit: RTL

Parametrised successor to the combinational ALU decoder. It merges control decode with execution for the multi-cycle RV32I/RV32M datapath. It decodes ALUOp/funct3/funct7 into a 4-bit ALUControl, executes single-cycle integer ops, and runs iterative multiply (shift-add) and divide (restoring) under a start/busy/done handshake. The multi-cycle controller FSM holds in its execute state until done.

---
 rtl/alu_seq_unit.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_unit.sv
// RV32I/RV32M ALU with integrated decode: single-cycle integer ops plus iterative
// shift-add multiply and restoring divide behind a start/busy/done handshake.
module alu_seq_unit #(
    parameter int unsigned XLEN   = 32,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      ALUOp,
    input  logic            Op5,
    input  logic [2:0]      fun3,
    input  logic            fun75,
    input  logic            fun70,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic [3:0]      ALUControl,
    output logic [XLEN-1:0] Result,
    output logic            Zero,
    output logic            busy,
    output logic            done,
    output logic            illegal
);
    localparam int unsigned     ShW     = $clog2(XLEN);
    localparam logic [ShW-1:0]  CntLast = ShW'(XLEN - 1);
    localparam logic [XLEN-1:0] MinInt  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StExec1, StMul, StDiv, StFin} state_e;

    // Internal op identity; several ALUControl codes are shared between base and M ops.
    typedef enum logic [4:0] {
        OpAdd, OpSub, OpPassB, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpSra, OpOr, OpAnd,
        OpMul, OpMulh, OpMulhsu, OpMulhu, OpDiv, OpDivu, OpRem, OpRemu
    } op_e;

    state_e              state_q, state_d;
    op_e                 op_q, op_d, dec_op;
    logic [3:0]          ctl_q, ctl_d, dec_ctl;
    logic [XLEN-1:0]     res_q, res_d, alu_res, fin_res;
    logic                zero_q, zero_d, busy_q, busy_d, done_q, done_d, ill_q, ill_d;
    logic                neg_q, neg_d;
    logic [2*XLEN-1:0]   acc_q, acc_d, acc_nx, mul_nx, div_nx, prod_fix;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [ShW-1:0]      cnt_q, cnt_d;

    logic                is_mul, is_div, is_m, a_signed, b_signed, a_neg, b_neg, neg_dec;
    logic                div_by_zero, div_ovf, div_special;
    logic [XLEN-1:0]     a_mag, b_mag, quot_fix, rem_fix;
    logic [ShW-1:0]      shamt;
    logic signed [XLEN-1:0] srca_s;
    logic [XLEN:0]       mul_add, mul_sum, div_sh, div_diff;

    always_comb begin
        dec_op  = OpAdd;
        dec_ctl = 4'b0010;
        unique case (ALUOp)
            2'b00: begin dec_op = OpAdd;   dec_ctl = 4'b0010; end
            2'b01: begin dec_op = OpSub;   dec_ctl = 4'b0110; end
            2'b11: begin dec_op = OpPassB; dec_ctl = 4'b1111; end
            default: begin
                if (Op5 && fun70) begin
                    unique case (fun3)
                        3'b000: begin dec_op = OpMul;    dec_ctl = 4'b1000; end
                        3'b001: begin dec_op = OpMulh;   dec_ctl = 4'b1001; end
                        3'b010: begin dec_op = OpMulhsu; dec_ctl = 4'b1010; end
                        3'b011: begin dec_op = OpMulhu;  dec_ctl = 4'b1011; end
                        3'b100: begin dec_op = OpDiv;    dec_ctl = 4'b1100; end
                        3'b101: begin dec_op = OpDivu;   dec_ctl = 4'b1101; end
                        3'b110: begin dec_op = OpRem;    dec_ctl = 4'b1110; end
                        default: begin dec_op = OpRemu;  dec_ctl = 4'b0100; end
                    endcase
                end else begin
                    unique case (fun3)
                        3'b000: begin
                            if (fun75 && Op5) begin dec_op = OpSub; dec_ctl = 4'b0110; end
                            else begin dec_op = OpAdd; dec_ctl = 4'b0010; end
                        end
                        3'b001: begin dec_op = OpSll;  dec_ctl = 4'b0011; end
                        3'b010: begin dec_op = OpSlt;  dec_ctl = 4'b0111; end
                        3'b011: begin dec_op = OpSltu; dec_ctl = 4'b0101; end
                        3'b100: begin dec_op = OpXor;  dec_ctl = 4'b1101; end
                        3'b101: begin
                            if (fun75) begin dec_op = OpSra; dec_ctl = 4'b1110; end
                            else begin dec_op = OpSrl; dec_ctl = 4'b1011; end
                        end
                        3'b110: begin dec_op = OpOr;   dec_ctl = 4'b0001; end
                        default: begin dec_op = OpAnd; dec_ctl = 4'b0000; end
                    endcase
                end
            end
        endcase
    end

    assign is_mul   = dec_op inside {OpMul, OpMulh, OpMulhsu, OpMulhu};
    assign is_div   = dec_op inside {OpDiv, OpDivu, OpRem, OpRemu};
    assign is_m     = is_mul || is_div;
    assign a_signed = dec_op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
    assign b_signed = dec_op inside {OpMulh, OpDiv, OpRem};
    assign a_neg    = a_signed && SrcA[XLEN-1];
    assign b_neg    = b_signed && SrcB[XLEN-1];
    assign a_mag    = a_neg ? -SrcA : SrcA;
    assign b_mag    = b_neg ? -SrcB : SrcB;
    // Remainder follows the dividend; quotient and signed products follow sign(A)^sign(B).
    assign neg_dec  = (dec_op == OpRem) ? a_neg : (a_neg ^ b_neg);

    assign div_by_zero = (SrcB == '0);
    assign div_ovf     = (dec_op inside {OpDiv, OpRem}) && (SrcA == MinInt) && (SrcB == '1);
    assign div_special = is_div && (div_by_zero || div_ovf);

    assign shamt  = SrcB[ShW-1:0];
    assign srca_s = SrcA;

    always_comb begin
        alu_res = '0;
        case (dec_op)
            OpAdd:          alu_res = SrcA + SrcB;
            OpSub:          alu_res = SrcA - SrcB;
            OpPassB:        alu_res = SrcB;
            OpSll:          alu_res = SrcA << shamt;
            OpSlt:          alu_res = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OpSltu:         alu_res = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
            OpXor:          alu_res = SrcA ^ SrcB;
            OpSrl:          alu_res = SrcA >> shamt;
            OpSra:          alu_res = srca_s >>> shamt;
            OpOr:           alu_res = SrcA | SrcB;
            OpAnd:          alu_res = SrcA & SrcB;
            OpDiv, OpDivu:  alu_res = div_by_zero ? '1 : SrcA;
            OpRem, OpRemu:  alu_res = div_by_zero ? SrcA : '0;
            default:        alu_res = '0;
        endcase
    end

    // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        mul_add  = acc_q[0] ? {1'b0, opnd_q} : '0;
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + mul_add;
        mul_nx   = {mul_sum, acc_q[XLEN-1:1]};
        div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff = div_sh - {1'b0, opnd_q};
        if (div_diff[XLEN]) div_nx = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else                div_nx = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        acc_nx   = (state_q == StMul) ? mul_nx : div_nx;
        prod_fix = neg_q ? -acc_nx : acc_nx;
        quot_fix = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
        rem_fix  = neg_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
        case (op_q)
            OpMul:                      fin_res = prod_fix[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu:  fin_res = prod_fix[2*XLEN-1:XLEN];
            OpDiv, OpDivu:              fin_res = quot_fix;
            default:                    fin_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        ctl_d   = ctl_q;
        res_d   = res_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        ill_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ctl_d = dec_ctl;
                    op_d  = dec_op;
                    neg_d = neg_dec;
                    cnt_d = '0;
                    if (is_m && !MUL_EN) begin
                        res_d   = '0;
                        ill_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = StExec1;
                    end else if (is_mul) begin
                        acc_d   = {{XLEN{1'b0}}, b_mag};
                        opnd_d  = a_mag;
                        busy_d  = 1'b1;
                        state_d = StMul;
                    end else if (is_div && !div_special) begin
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        opnd_d  = b_mag;
                        busy_d  = 1'b1;
                        state_d = StDiv;
                    end else begin
                        res_d   = alu_res;
                        done_d  = 1'b1;
                        state_d = StExec1;
                    end
                end
            end
            StMul, StDiv: begin
                acc_d = acc_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    res_d   = fin_res;
                    done_d  = 1'b1;
                    state_d = StFin;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        zero_d = (res_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= OpAdd;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            ctl_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            ctl_q   <= ctl_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ill_q   <= ill_d;
        end
    end

    assign ALUControl = ctl_q;
    assign Result     = res_q;
    assign Zero       = zero_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign illegal    = ill_q;

endmodule
